elpis_sram_rv: RTL



---
 rtl/elpis_sram_rv_pkg.sv | 25 ++
 rtl/elpis_sram_rsp_fifo.sv | 75 +++++++
 rtl/elpis_sram_rv.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/elpis_sram_rv_pkg.sv
// elpis_sram_rv_pkg
//   Shared definitions for the Elpis valid/ready SRAM.
//   - SRAM_DEFAULT_DATA_W / SRAM_DEFAULT_ADDR_W / SRAM_DEFAULT_DEPTH: default geometry
//   - SRAM_LAT_1 / SRAM_LAT_2: legal read-latency encodings
//   - req_kind_e: decode of the req_we request bit
//   - byte_parity(): even parity of one byte (used by the SRAM_PARITY_EN build)
package elpis_sram_rv_pkg;

  localparam int SRAM_DEFAULT_DATA_W = 32;
  localparam int SRAM_DEFAULT_ADDR_W = 20;
  localparam int SRAM_DEFAULT_DEPTH  = 1024;

  localparam int SRAM_LAT_1 = 1;
  localparam int SRAM_LAT_2 = 2;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/elpis_sram_rsp_fifo.sv
// elpis_sram_rsp_fifo
//   Response buffer for elpis_sram_rv. Valid/ready on both sides. When the
//   buffer is empty the input is passed straight to the output in the same
//   cycle, so an unstalled response sees no added latency.
//   Parameters: WIDTH (payload bits), DEPTH (entries, any value >= 1).
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     in_valid/in_ready/in_data    producer side
//     out_valid/out_ready/out_data consumer side
module elpis_sram_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, bypass, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  assign in_ready  = !full;
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : store_q[rd_ptr_q];

  // An input that is consumed directly by the output is never stored.
  assign bypass = empty && out_ready;
  assign push   = in_valid && !full && !bypass;
  assign pop    = !empty && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap explicitly so DEPTH need not be a power of two.
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/elpis_sram_rv.sv
// elpis_sram_rv
//   Single-port synchronous SRAM behind a valid/ready request port, with
//   per-byte write enables, READ_LAT (1 or 2) cycle reads and a response
//   FIFO sized RSP_DEPTH. A credit counter limits outstanding reads to the
//   FIFO size so responses never need to stall the read pipeline.
//   Optional feature macro: SRAM_PARITY_EN (per-byte even parity, reported
//   on parity_err alongside the response). Without it parity_err is 0.
//   Ports:
//     clk, reset_n                         clock, asynchronous active-low reset
//     req_valid/req_ready                  request handshake
//     req_we, req_addr, req_wdata, req_be  write flag, word address, data, byte enables
//     rsp_valid/rsp_ready, rsp_rdata       read response handshake and data
//     parity_err                           parity mismatch, qualified by rsp_valid
module elpis_sram_rv
  import elpis_sram_rv_pkg::*;
#(
  parameter int DATA_W    = SRAM_DEFAULT_DATA_W,
  parameter int ADDR_W    = SRAM_DEFAULT_ADDR_W,
  parameter int DEPTH     = SRAM_DEFAULT_DEPTH,
  parameter int READ_LAT  = SRAM_LAT_1,
  parameter int RSP_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                parity_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CRED_W = $clog2(RSP_DEPTH + 1);
`ifdef SRAM_PARITY_EN
  localparam int PAY_W  = DATA_W + 1;
`else
  localparam int PAY_W  = DATA_W;
`endif

  req_kind_e         req_kind;
  logic              accept, rd_accept, wr_accept, addr_in_range, rsp_pop;
  logic [IDX_W-1:0]  idx;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [DATA_W-1:0] mem [DEPTH];

  assign req_kind  = req_kind_e'(req_we);
  assign req_ready = (credit_q != '0);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && (req_kind == REQ_READ);
  assign wr_accept = accept && (req_kind == REQ_WRITE);

  // Compare one bit wider so DEPTH == 2**ADDR_W does not wrap to zero.
  assign addr_in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
  assign idx           = req_addr[IDX_W-1:0];

  // Storage array is not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_accept && addr_in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [PAY_W-1:0]  s1_pay;

  always_comb begin
    s1_valid_d = rd_accept;
    s1_data_d  = s1_data_q;
    if (rd_accept) s1_data_d = addr_in_range ? mem[idx] : '0;
  end

`ifdef SRAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] s1_par_q, s1_par_d;
  logic            s1_err;

  always_ff @(posedge clk) begin
    if (wr_accept && addr_in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) par_mem[idx][i] <= byte_parity(req_wdata[8*i +: 8]);
      end
    end
  end

  // Out-of-range reads carry zero data and zero parity, so they never flag.
  always_comb begin
    s1_par_d = s1_par_q;
    if (rd_accept) s1_par_d = addr_in_range ? par_mem[idx] : '0;
  end

  always_comb begin
    s1_err = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (byte_parity(s1_data_q[8*i +: 8]) != s1_par_q[i]) s1_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_par_q <= '0;
    else          s1_par_q <= s1_par_d;
  end

  assign s1_pay = {s1_err, s1_data_q};
`else
  assign s1_pay = s1_data_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  logic             pipe_valid;
  logic [PAY_W-1:0] pipe_pay;

  if (READ_LAT == SRAM_LAT_2) begin : g_lat2
    logic             s2_valid_q, s2_valid_d;
    logic [PAY_W-1:0] s2_pay_q, s2_pay_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_pay_d   = s1_valid_q ? s1_pay : s2_pay_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid_q <= 1'b0;
        s2_pay_q   <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_pay_q   <= s2_pay_d;
      end
    end

    assign pipe_valid = s2_valid_q;
    assign pipe_pay   = s2_pay_q;
  end else begin : g_lat1
    assign pipe_valid = s1_valid_q;
    assign pipe_pay   = s1_pay;
  end

  logic             fifo_in_ready;
  logic [PAY_W-1:0] rsp_pay;

  elpis_sram_rsp_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (pipe_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (pipe_pay),
    .out_valid (rsp_valid),
    .out_ready (rsp_ready),
    .out_data  (rsp_pay)
  );

  // Credits bound in-flight plus buffered reads to RSP_DEPTH, so the
  // pipeline never presents a response to a full FIFO.
  a_fifo_space: assert property (@(posedge clk) disable iff (!reset_n)
                                 pipe_valid |-> fifo_in_ready);

`ifdef SRAM_PARITY_EN
  logic rsp_err;
  assign {rsp_err, rsp_rdata} = rsp_pay;
  assign parity_err           = rsp_valid && rsp_err;
`else
  assign rsp_rdata  = rsp_pay;
  assign parity_err = 1'b0;
`endif

  assign rsp_pop = rsp_valid && rsp_ready;

  always_comb begin
    case ({rd_accept, rsp_pop})
      2'b10:   credit_d = credit_q - CRED_W'(1);
      2'b01:   credit_d = credit_q + CRED_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) credit_q <= CRED_W'(RSP_DEPTH);
    else          credit_q <= credit_d;
  end

endmodule
